// File: rtl/shift_register.sv
// Bidirectional serial-in / parallel-out shift register with clock enable.
// Define SHIFT_REGISTER_SOUT_EN to add the registered serial-out port sout.
module shift_register #(
  parameter int n = 8
) (
  input  logic         I,
  input  logic         clk,
  input  logic         direction,
  input  logic         reset,
  output logic [n-1:0] D,
  input  logic         enable
`ifdef SHIFT_REGISTER_SOUT_EN
  ,
  output logic         sout
`endif
);

  // direction 0 moves bits toward the MSB, 1 toward the LSB; I fills the vacated end.
  function automatic logic [n-1:0] shift_next(input logic [n-1:0] cur,
                                              input logic dir,
                                              input logic din);
    logic [n-1:0] nxt;
    if (dir)
      nxt = {din, cur[n-1:1]};
    else
      nxt = {cur[n-2:0], din};
    return nxt;
  endfunction

  function automatic logic dropped_bit(input logic [n-1:0] cur, input logic dir);
    return dir ? cur[0] : cur[n-1];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      D <= '0;
    else if (enable)
      D <= shift_next(D, direction, I);
  end

`ifdef SHIFT_REGISTER_SOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sout <= 1'b0;
    else if (enable)
      sout <= dropped_bit(D, direction);
  end
`else
  // Discarded bit has no consumer in this build.
  logic unused_drop;
  assign unused_drop = dropped_bit(D, direction);
`endif

endmodule

// File: tb/tb_shift_register.sv
// Scoreboarded random/directed bench for shift_register (optionally with sout).
module tb_shift_register;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         I = 1'b1;
  logic         direction = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b1;
  logic [N-1:0] D;
`ifdef SHIFT_REGISTER_SOUT_EN
  logic         sout;
`endif

  shift_register #(.n(N)) dut (
    .I(I),
    .clk(clk),
    .direction(direction),
    .reset(reset),
    .D(D),
    .enable(enable)
`ifdef SHIFT_REGISTER_SOUT_EN
    ,
    .sout(sout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    logic         s;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: register value as an integer and the last dropped bit.
  int unsigned model_d = 0;
  bit          model_s = 0;
  int unsigned mask = (1 << N) - 1;

  task automatic compare(input string name, input logic [N-1:0] got_d,
                         input logic got_s, input logic [N-1:0] want_d,
                         input logic want_s);
    checks++;
    if (got_d !== want_d) begin
      errors++;
      $display("FAIL %s D got %b want %b", name, got_d, want_d);
    end
`ifdef SHIFT_REGISTER_SOUT_EN
    checks++;
    if (got_s !== want_s) begin
      errors++;
      $display("FAIL %s sout got %b want %b", name, got_s, want_s);
    end
`endif
  endtask

  function automatic logic cur_sout();
`ifdef SHIFT_REGISTER_SOUT_EN
    return sout;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: each edge preceded by a scheduled stimulus has one expected entry.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      compare(e.name, D, cur_sout(), e.d, e.s);
    end
  end

  // Drive the inputs for the next edge and predict its result.
  task automatic step(input logic rst_v, input logic en, input logic dir,
                      input logic din, input string name);
    exp_t e;
    @(negedge clk);
    reset = rst_v; enable = en; direction = dir; I = din;
    if (!rst_v) begin
      model_d = 0; model_s = 0;
    end else if (en) begin
      if (dir) begin
        model_s = model_d[0];
        model_d = (model_d >> 1) | (int'(din) << (N - 1));
      end else begin
        model_s = model_d[N-1];
        model_d = ((model_d << 1) | int'(din)) & mask;
      end
    end
    e.d = model_d[N-1:0]; e.s = model_s; e.name = name;
    exp_q.push_back(e);
  endtask

  // Independent check of a test-plan constant right after the pending edge.
  task automatic expect_d(input logic [N-1:0] want, input string name);
    @(posedge clk);
    #2;
    checks++;
    if (D !== want) begin
      errors++;
      $display("FAIL %s D got %b want %b", name, D, want);
    end
  endtask

  // Drop reset between edges and confirm the clear is immediate.
  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_d = 0; model_s = 0;
    #1;
    compare(name, D, cur_sout(), '0, 1'b0);
  endtask

  // Drop reset at the same instant as a rising edge.
  task automatic coincident_reset();
    exp_t e;
    @(negedge clk);
    enable = 1'b1; I = 1'b1; direction = $urandom_range(0, 1);
    model_d = 0; model_s = 0;
    e.d = '0; e.s = 1'b0; e.name = "coincident_reset";
    exp_q.push_back(e);
    @(posedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    #3;
    compare("reset_t3", D, cur_sout(), '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, "reset_held");
    step(1'b1, 1'b1, 1'b0, 1'b1, "release");
    expect_d(8'b00000001, "release_const");

    step(1'b0, 1'b1, 1'b0, 1'b1, "clear");
    step(1'b1, 1'b1, 1'b0, 1'b1, "left1");
    step(1'b1, 1'b1, 1'b0, 1'b0, "left2");
    step(1'b1, 1'b1, 1'b0, 1'b1, "left3");
    step(1'b1, 1'b1, 1'b0, 1'b0, "left4");
    expect_d(8'b00001010, "left_const");
    step(1'b1, 1'b1, 1'b1, 1'b1, "right1");
    step(1'b1, 1'b1, 1'b1, 1'b0, "right2");
    step(1'b1, 1'b1, 1'b1, 1'b1, "right3");
    step(1'b1, 1'b1, 1'b1, 1'b0, "right4");
    expect_d(8'b01010000, "right_const");
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b0, k[0], ~k[1], "hold");
    expect_d(8'b01010000, "hold_const");
    step(1'b1, 1'b1, 1'b0, 1'b1, "reenable");
    expect_d(8'b10100001, "reenable_const");

    for (int k = 0; k < N; k++)
      step(1'b1, 1'b1, 1'b0, 1'b1, "fill_ones");
    expect_d(8'b11111111, "ones_const");
    async_reset("async_reset");
    step(1'b0, 1'b1, 1'b0, 1'b1, "reset_low_edge");
    step(1'b0, 1'b1, 1'b1, 1'b1, "reset_low_edge");

    for (int k = 0; k < N; k++)
      step(1'b1, 1'b1, 1'b0, (k == 0 || k == N - 1), "load_81");
    expect_d(8'b10000001, "load_81_const");
    step(1'b1, 1'b1, 1'b0, 1'b0, "sout_left");
    step(1'b1, 1'b1, 1'b1, 1'b0, "sout_right");
    expect_d(8'b00000001, "sout_right_const");

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 60) == 0)
        async_reset("rand_async_reset");
      else if ($urandom_range(0, 80) == 0)
        coincident_reset();
      step($urandom_range(0, 30) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1), $urandom_range(0, 1), "random");
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
